// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, one key per press.
// Key storage is a single register by default; define KEYPAD_KEY_FIFO_EN for a 4-entry FIFO.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 27000,
  parameter int unsigned DEBOUNCE_CYC = 540000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overrun
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        meta_q, fs_q;
  logic [3:0]        col_q, col_d;
  logic [3:0]        col_next;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [3:0]        ref_q, ref_d;
  logic              down_q, down_d;
  logic              push;
  logic [1:0]        row_idx, col_idx;
  logic [3:0]        new_key;
  logic              overrun_q, overrun_d;

  // Rows are asynchronous to clk; nothing downstream looks at fila directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'hF;
      fs_q   <= 4'hF;
    end else begin
      meta_q <= fila;
      fs_q   <= meta_q;
    end
  end

  assign col_next = {col_q[2:0], col_q[3]};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    slot_d  = slot_q;
    deb_d   = deb_q;
    ref_d   = ref_q;
    down_d  = down_q;
    push    = 1'b0;
    case (state_q)
      SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (fs_q != 4'hF) begin
            state_d = DEBOUNCE;
            ref_d   = fs_q;
            deb_d   = '0;
          end else begin
            col_d = col_next;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (fs_q == ref_q) begin
          if (deb_q == DEB_LAST) begin
            state_d = HELD;
            down_d  = 1'b1;
            push    = 1'b1;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          col_d   = col_next;
          slot_d  = '0;
          deb_d   = '0;
        end
      end
      HELD: begin
        if (fs_q == 4'hF) begin
          state_d = RELEASE;
          deb_d   = '0;
        end
      end
      RELEASE: begin
        if (fs_q == 4'hF) begin
          if (deb_q == DEB_LAST) begin
            state_d = SCAN;
            down_d  = 1'b0;
            col_d   = col_next;
            slot_d  = '0;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          state_d = HELD;
          deb_d   = '0;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= 4'b1110;
      slot_q    <= '0;
      deb_q     <= '0;
      ref_q     <= 4'hF;
      down_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      slot_q    <= slot_d;
      deb_q     <= deb_d;
      ref_q     <= ref_d;
      down_q    <= down_d;
      overrun_q <= overrun_d;
    end
  end

  // Descending loop so the lowest-index low bit wins when several rows are low.
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!ref_q[i]) row_idx = 2'(i);
      if (!col_q[i]) col_idx = 2'(i);
    end
  end

  assign new_key = {row_idx, col_idx};

`ifdef KEYPAD_KEY_FIFO_EN
  logic [3:0] fifo_mem [4];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;
  logic       fifo_full, fifo_pop, fifo_push;

  // A pop frees the head slot on the same edge, so a push into a full FIFO can still land.
  always_comb begin
    fifo_full = (count_q == 3'd4);
    fifo_pop  = (count_q != 3'd0) && key_ready;
    fifo_push = push && (!fifo_full || fifo_pop);
    overrun_d = push && fifo_full && !fifo_pop;
    rd_ptr_d  = fifo_pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    wr_ptr_d  = fifo_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    count_d   = count_q + {2'b00, fifo_push} - {2'b00, fifo_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= new_key;
  end

  assign key_valid = (count_q != 3'd0);
  assign key_code  = key_valid ? fifo_mem[rd_ptr_q] : 4'h0;
`else
  logic [3:0] key_q, key_d;
  logic       valid_q, valid_d;

  always_comb begin
    key_d     = key_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (push) begin
      key_d     = new_key;
      valid_d   = 1'b1;
      overrun_d = valid_q && !key_ready;
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = key_q;
`endif

  assign columna  = col_q;
  assign key_down = down_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model gates rows by the driven column; delivered
// keys are scored against an expected-key queue built from each press's row/column.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;
  localparam int PRESS_BUDGET   = 8 + DC + 5 * SD;
  localparam int RELEASE_BUDGET = DC + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fila = 4'hF;
  logic [3:0] columna;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic       overrun;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .fila      (fila),
    .columna   (columna),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] exp_q[$];
  int         exp_ov = 0;
  int         ov_cycles = 0;
  logic       press_on = 1'b0;
  logic [3:0] press_rows = 4'h0;
  int         press_col = 0;
  logic       raw_mode = 1'b0;
  logic [3:0] raw_fila = 4'hF;
  logic       rand_ready = 1'b0;
  logic       ready_cmd = 1'b0;
  logic [3:0] prev_col = 4'b1110;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int low_index(input logic [3:0] v);
    int r = 0;
    while (r < 3 && v[r] != 1'b0) r++;
    return r;
  endfunction

  function automatic logic [3:0] model_key(input logic [3:0] rows, input int col);
    int r = 0;
    while (r < 3 && !rows[r]) r++;
    return 4'(r * 4 + col);
  endfunction

  task automatic model_push(input logic [3:0] k);
`ifdef KEYPAD_KEY_FIFO_EN
    if (exp_q.size() == 4) exp_ov++;
    else exp_q.push_back(k);
`else
    if (exp_q.size() == 1) begin
      exp_q[0] = k;
      exp_ov++;
    end else begin
      exp_q.push_back(k);
    end
`endif
  endtask

  // One clock: drive inputs just after the edge, observe at the falling edge.
  task automatic tick();
    logic [3:0] want;
    @(posedge clk);
    #1;
    key_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    if (raw_mode) fila = raw_fila;
    else if (press_on && columna[press_col] == 1'b0) fila = ~press_rows;
    else fila = 4'hF;
    @(negedge clk);
    if (!rst) begin
      if (columna != prev_col) begin
        want = ~(4'b0001 << ((low_index(prev_col) + 1) % 4));
        check_eq("col_rotate", columna, want);
        prev_col = columna;
      end
      if (overrun) ov_cycles++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_key", key_valid, 1'b0);
        else check_eq("key_code", key_code, exp_q.pop_front());
      end
    end
  endtask

  task automatic wait_down(input logic lvl, input int budget, output int n);
    n = 0;
    while (key_down !== lvl && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_press(input logic [3:0] rows, input int col, input int hold);
    int n;
    int bad;
    model_push(model_key(rows, col));
    press_rows = rows;
    press_col  = col;
    press_on   = 1'b1;
    wait_down(1'b1, PRESS_BUDGET, n);
    check_eq("press_in_budget", n < PRESS_BUDGET, 1);
    check_eq("press_not_early", n >= 2 + DC, 1);
    bad = 0;
    repeat (hold) begin
      tick();
      if (key_down !== 1'b1) bad++;
    end
    check_eq("held_key_down", bad, 0);
    press_on = 1'b0;
    wait_down(1'b0, RELEASE_BUDGET, n);
    check_eq("release_in_budget", n < RELEASE_BUDGET, 1);
    check_eq("release_not_early", n >= DC, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_columna"}, columna, 4'b1110);
    check_eq({tag, "_key_code"}, key_code, 4'h0);
    check_eq({tag, "_key_valid"}, key_valid, 1'b0);
    check_eq({tag, "_key_down"}, key_down, 1'b0);
    check_eq({tag, "_overrun"}, overrun, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;
    int g;
    logic [3:0] rows;

    // Reset state and idle scan cadence.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (columna !== ~(4'b0001 << ((i / SD) % 4))) bad++;
      if (key_valid !== 1'b0) bad++;
      tick();
    end
    check_eq("idle_scan", bad, 0);

    // Single press on row 1 / column 2, no auto-repeat during a long hold.
    ready_cmd = 1'b0;
    do_press(4'b0010, 2, 30);
    check_eq("press_key_code", key_code, 4'b0110);
    check_eq("press_key_valid", key_valid, 1'b1);
    ready_cmd = 1'b1;
    repeat (10) tick();
    check_eq("press_drained", exp_q.size(), 0);
    check_eq("press_valid_after", key_valid, 1'b0);

    // Short glitch on row 0 must not produce a key.
    raw_mode = 1'b1;
    raw_fila = 4'b1110;
    repeat (6) tick();
    raw_fila = 4'hF;
    bad = 0;
    repeat (40) begin
      tick();
      if (key_down !== 1'b0 || key_valid !== 1'b0) bad++;
    end
    raw_mode = 1'b0;
    check_eq("glitch_no_key", bad, 0);

    // Several rows low in one column: lowest row wins.
    do_press(4'b1100, 1, 5);
    repeat (6) tick();
    check_eq("multi_row_drained", exp_q.size(), 0);

    // Overflow behaviour with the consumer stalled.
    ready_cmd = 1'b0;
    ov_cycles = 0;
    exp_ov = 0;
`ifdef KEYPAD_KEY_FIFO_EN
    do_press(4'b0001, 0, 2);
    do_press(4'b0010, 1, 2);
    do_press(4'b0100, 2, 2);
    do_press(4'b1000, 3, 2);
    do_press(4'b0001, 3, 2);
    repeat (4) tick();
    check_eq("fifo_overrun", ov_cycles, exp_ov);
    check_eq("fifo_head", key_code, exp_q[0]);
`else
    do_press(4'b0001, 0, 2);
    do_press(4'b0010, 1, 2);
    repeat (4) tick();
    check_eq("reg_overrun", ov_cycles, exp_ov);
    check_eq("reg_key_code", key_code, 4'b0101);
    check_eq("reg_key_valid", key_valid, 1'b1);
`endif
    ready_cmd = 1'b1;
    repeat (10) tick();
    check_eq("overflow_drained", exp_q.size(), 0);

    // Randomized presses and glitches with a randomly stalling consumer.
    rand_ready = 1'b1;
    ov_cycles = 0;
    exp_ov = 0;
    for (int t = 0; t < 14; t++) begin
      rows = 4'($urandom_range(1, 15));
      n = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        press_rows = rows;
        press_col  = n;
        press_on   = 1'b1;
        g = $urandom_range(1, DC - 1);
        repeat (g) tick();
        press_on = 1'b0;
      end else begin
        do_press(rows, n, $urandom_range(0, 20));
      end
      repeat ($urandom_range(3, 12)) tick();
    end
    rand_ready = 1'b0;
    ready_cmd = 1'b1;
    repeat (10) tick();
    check_eq("random_drained", exp_q.size(), 0);
    check_eq("random_no_overrun", ov_cycles, exp_ov);

    // Asynchronous reset while a key is held; the press is re-detected afterwards.
    ready_cmd = 1'b0;
    model_push(model_key(4'b0100, 3));
    press_rows = 4'b0100;
    press_col  = 3;
    press_on   = 1'b1;
    wait_down(1'b1, PRESS_BUDGET, n);
    check_eq("held_before_reset", key_down, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    exp_ov = 0;
    ov_cycles = 0;
    prev_col = 4'b1110;
    repeat (2) tick();
    rst = 1'b0;
    model_push(model_key(4'b0100, 3));
    ready_cmd = 1'b1;
    wait_down(1'b1, PRESS_BUDGET, n);
    check_eq("redetect_in_budget", n < PRESS_BUDGET, 1);
    press_on = 1'b0;
    wait_down(1'b0, RELEASE_BUDGET, n);
    repeat (6) tick();
    check_eq("redetect_drained", exp_q.size(), 0);
    check_eq("redetect_overrun", ov_cycles, exp_ov);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 27000: clocks per column slot (1 ms at 27 MHz); legal range 4 or more.
REQ-002 Parameter DEBOUNCE_CYC, default 540000: consecutive stable clocks required for press and for release (20 ms); legal range 2 or more.
REQ-003 clk  input  1  system clock, 27 MHz; the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fila  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 columna  output  4  keypad column drive, active-low one-hot.
REQ-007 key_code  output  4  key identifier, {row_idx[1:0], col_idx[1:0]}.
REQ-008 key_valid  output  1  key_code holds an undelivered key.
REQ-009 key_ready  input  1  consumer accepts key_code this cycle.
REQ-010 key_down  output  1  level; a debounced key is currently held.
REQ-011 overrun  output  1  one-cycle pulse when a key is lost.

Function
REQ-012 fila shall pass through a 2-flop synchronizer; all decisions shall use the synchronized value (fs).
REQ-013 The FSM states shall be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-014 In SCAN, columna shall rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, holding each pattern for SCAN_DIV clocks.
REQ-015 In SCAN, fs shall be sampled only on the last clock of each slot; if fs != 1111, the FSM shall enter DEBOUNCE, freeze columna, and latch fs as the reference.
REQ-016 In DEBOUNCE, a counter shall increment each clock while fs equals the reference.
REQ-017 In DEBOUNCE, any mismatch shall return the FSM to SCAN at the next column with the counter cleared.
REQ-018 When the DEBOUNCE counter reaches DEBOUNCE_CYC, the FSM shall enter HELD, raise key_down, and push one key on the same clock.
REQ-019 If multiple rows are low, row_idx shall be the lowest-index low bit; col_idx shall be the index of the low columna bit.
REQ-020 In HELD, the FSM shall stay while fs != 1111; it shall emit no further keys (no auto-repeat); columna shall stay frozen.
REQ-021 In HELD, when fs == 1111 the FSM shall enter RELEASE.
REQ-022 In RELEASE, DEBOUNCE_CYC consecutive clocks of fs == 1111 shall clear key_down and return the FSM to SCAN at the next column.
REQ-023 In RELEASE, any fs != 1111 shall return the FSM to HELD with the counter cleared.
REQ-024 Handshake: a key shall transfer on a clock where key_valid and key_ready are both 1.
REQ-025 key_ready while key_valid=0 shall be ignored.
REQ-026 Press-to-key_valid latency shall be 2 (synchronizer) + DEBOUNCE_CYC + at most 4*SCAN_DIV clocks.

Reset
REQ-027 While rst is high, asynchronously: FSM=SCAN, columna=1110, slot counter=0, debounce counter=0, synchronizer=1111, key_code=0, key_valid=0, key_down=0, overrun=0, FIFO empty.
REQ-028 Reset mid-press shall discard the press.
REQ-029 After reset, a key still held shall be re-detected as a new press once scanning resumes.

Configuration
REQ-030 The controlling macro shall be KEYPAD_KEY_FIFO_EN.
REQ-031 With KEYPAD_KEY_FIFO_EN undefined: storage shall be a single register.
REQ-032 Single register: a push while key_valid=1 and key_ready=0 shall overwrite key_code and pulse overrun.
REQ-033 Single register: a push in the same clock as an accept shall load the new key with key_valid staying 1 and no overrun.
REQ-034 With KEYPAD_KEY_FIFO_EN defined: storage shall be a 4-entry FIFO; key_valid shall be not-empty; key_code shall be the head entry.
REQ-035 FIFO: a push when full with no pop shall drop the new key, pulse overrun, and leave contents unchanged.
REQ-036 FIFO: push and pop in the same clock when full shall both succeed and occupancy shall stay 4.
REQ-037 FIFO: the read pointer, write pointer and occupancy counter shall wrap modulo 4.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8)
REQ-038 After reset with fila=1111: columna shall cycle 1110,1101,1011,0111 with 4 clocks per pattern; key_valid shall stay 0.
REQ-039 fila=1101 held while columna=1011 -> key_code=0110 and key_valid=1 once; key_down=1 until 8 clean release clocks; no second key.
REQ-040 fila=1110 glitch shorter than 8 clocks -> no key; scanning resumes at the next column.
REQ-041 No FIFO, key_ready=0, two presses (0000 then 0101) -> overrun pulses 1 clock; key_code=0101.
REQ-042 FIFO build, key_ready=0, five presses -> first four kept in order; fifth drops with an overrun pulse; key_ready=1 then drains 4 keys in order.
REQ-043 rst asserted during HELD -> all outputs return to reset values immediately, before the next clk edge.
